// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: op request, divider and multiplier handshake bundle for the HI/LO sequencer
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        op_ready, stall;
  logic [31:0] rd_data, hi_out, lo_out;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic        div_done, div_by_zero;
  logic [31:0] div_quotient, div_remainder;
  logic        mul_start, mul_done;
  logic [63:0] mul_product;
  logic        op_done, div_zero_exc, timeout_err, illegal_op;
  modport master (
    output op_valid, op_code, rs_val, rt_val, div_done, div_by_zero, div_quotient, div_remainder,
           mul_done, mul_product,
    input  op_ready, stall, rd_data, hi_out, lo_out, div_start, div_a, div_b, mul_start,
           op_done, div_zero_exc, timeout_err, illegal_op
  );
  modport slave (
    input  op_valid, op_code, rs_val, rt_val, div_done, div_by_zero, div_quotient, div_remainder,
           mul_done, mul_product,
    output op_ready, stall, rd_data, hi_out, lo_out, div_start, div_a, div_b, mul_start,
           op_done, div_zero_exc, timeout_err, illegal_op
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/DIV/move ops onto the external multiplier and divider and owns HI/LO
module muldiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DIV_ISSUE, DIV_WAIT, MUL_ISSUE, MUL_WAIT} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT - 1);
  state_t          r_state;
  logic [CNT_W-1:0] r_wdog;
  logic [31:0]     r_hi, r_lo, r_div_a, r_div_b;
  logic            r_div_start, r_mul_start, r_op_done, r_dz, r_to, r_ill;
  logic            w_idle, w_wait, w_done, w_expire;
  assign w_idle   = r_state == IDLE;
  assign w_wait   = r_state == DIV_WAIT || r_state == MUL_WAIT;
  assign w_done   = r_state == DIV_WAIT ? bus.div_done : bus.mul_done;
  assign w_expire = w_wait && !w_done && r_wdog == LIM;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wdog      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_start <= 1'b0;
      r_mul_start <= 1'b0;
      r_op_done   <= 1'b0;
      r_dz        <= 1'b0;
      r_to        <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      r_mul_start <= 1'b0;
      r_op_done   <= 1'b0;
      r_dz        <= 1'b0;
      r_to        <= w_expire;
      r_ill       <= 1'b0;
      // zero outside WAIT so every WAIT entry starts counting from 0
      r_wdog      <= w_wait ? r_wdog + 1'b1 : '0;
      unique case (r_state)
        IDLE: if (bus.op_valid) begin
          case (bus.op_code)
            3'b001: begin
              r_state     <= MUL_ISSUE;
              r_mul_start <= 1'b1;
            end
            3'b010: begin
              r_state     <= DIV_ISSUE;
              r_div_start <= 1'b1;
              r_div_a     <= bus.rs_val;
              r_div_b     <= bus.rt_val;
            end
            3'b101:  r_hi  <= bus.rs_val;
            3'b110:  r_lo  <= bus.rs_val;
            3'b111:  r_ill <= 1'b1;
            default: ;
          endcase
        end
        DIV_ISSUE: r_state <= DIV_WAIT;
        MUL_ISSUE: r_state <= MUL_WAIT;
        DIV_WAIT: begin
          if (bus.div_done || w_expire) r_state <= IDLE;
          if (bus.div_done && bus.div_by_zero) r_dz <= 1'b1;
          if (bus.div_done && !bus.div_by_zero) begin
            r_lo      <= bus.div_quotient;
            r_hi      <= bus.div_remainder;
            r_op_done <= 1'b1;
          end
        end
        MUL_WAIT: begin
          if (bus.mul_done || w_expire) r_state <= IDLE;
          if (bus.mul_done) begin
            {r_hi, r_lo} <= bus.mul_product;
            r_op_done    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.op_ready     = w_idle;
  assign bus.stall        = !w_idle;
  assign bus.rd_data      = bus.op_code == 3'b011 ? r_hi : bus.op_code == 3'b100 ? r_lo : '0;
  assign bus.hi_out       = r_hi;
  assign bus.lo_out       = r_lo;
  assign bus.div_start    = r_div_start;
  assign bus.div_a        = r_div_a;
  assign bus.div_b        = r_div_b;
  assign bus.mul_start    = r_mul_start;
  assign bus.op_done      = r_op_done;
  assign bus.div_zero_exc = r_dz;
  assign bus.timeout_err  = r_to;
  assign bus.illegal_op   = r_ill;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench with behavioural divider/multiplier and a HI/LO reference model
module tb_muldiv_ctrl;
  localparam int TIMEOUT = 40;
  localparam int K_DONE = 0, K_DZ = 1, K_TO = 2, K_ILL = 3;
  typedef struct {int kind; logic [31:0] hi; logic [31:0] lo;} exp_t;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  muldiv_ctrl_if bus();
  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t sb[$];
  exp_t me;
  int mk;
  int n_cmp = 0, n_err = 0;
  int n_div = 0, n_mul = 0, n_dstart = 0, n_mstart = 0, n_stall_bad = 0;
  int dlat = 5, mlat = 3, dcnt = 0, mcnt = 0;
  bit den = 1'b1;
  logic [31:0] m_hi = '0, m_lo = '0, ma = '0, mb = '0;
  logic d_done = 1'b0, d_dz = 1'b0, p_done = 1'b0;
  logic [31:0] d_q = '0, d_r = '0;
  logic [63:0] p_prod = '0;
  assign bus.div_done = d_done;
  assign bus.div_by_zero = d_dz;
  assign bus.div_quotient = d_q;
  assign bus.div_remainder = d_r;
  assign bus.mul_done = p_done;
  assign bus.mul_product = p_prod;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // external divider: done is a level that drops on start and rises dlat cycles later
  always @(posedge clk) begin
    if (bus.div_start) begin
      d_done <= 1'b0;
      dcnt <= dlat;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && den) begin
        d_done <= 1'b1;
        d_dz <= bus.div_b == 0;
        d_q <= bus.div_b == 0 ? 32'hFFFF_FFFF : 32'(longint'($signed(bus.div_a)) / longint'($signed(bus.div_b)));
        d_r <= bus.div_b == 0 ? bus.div_a : 32'(longint'($signed(bus.div_a)) % longint'($signed(bus.div_b)));
      end
    end
  end
  always @(posedge clk) begin
    if (bus.mul_start) begin
      p_done <= 1'b0;
      mcnt <= mlat;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        p_done <= 1'b1;
        p_prod <= 64'(longint'($signed(ma)) * longint'($signed(mb)));
      end
    end
  end
  always @(negedge clk) begin
    if (bus.div_start) n_dstart++;
    if (bus.mul_start) n_mstart++;
    if (bus.stall !== ~bus.op_ready) n_stall_bad++;
    if (bus.op_done | bus.div_zero_exc | bus.timeout_err | bus.illegal_op) begin
      mk = bus.op_done ? K_DONE : bus.div_zero_exc ? K_DZ : bus.timeout_err ? K_TO : K_ILL;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got kind %0d expected none", mk);
      end else begin
        me = sb.pop_front();
        check("event_kind", mk, me.kind);
        check("event_pulses", $countones({bus.op_done, bus.div_zero_exc, bus.timeout_err, bus.illegal_op}), 1);
        check("event_hi", bus.hi_out, me.hi);
        check("event_lo", bus.lo_out, me.lo);
      end
    end
  end
  task automatic wait_ready();
    int t = 0;
    while (!bus.op_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.op_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_wait: got busy after %0d cycles expected ready", t);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    wait_ready();
    bus.op_valid = 1'b1;
    bus.op_code = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    case (op)
      3'd1: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        ma = a;
        mb = b;
        {m_hi, m_lo} = p;
        sb.push_back('{K_DONE, m_hi, m_lo});
        n_mul++;
      end
      3'd2: begin
        n_div++;
        if (!den) sb.push_back('{K_TO, m_hi, m_lo});
        else if (b == 0) sb.push_back('{K_DZ, m_hi, m_lo});
        else begin
          m_lo = 32'(longint'($signed(a)) / longint'($signed(b)));
          m_hi = 32'(longint'($signed(a)) % longint'($signed(b)));
          sb.push_back('{K_DONE, m_hi, m_lo});
        end
      end
      3'd3: check("mfhi_rd", bus.rd_data, m_hi);
      3'd4: check("mflo_rd", bus.rd_data, m_lo);
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      3'd7: sb.push_back('{K_ILL, m_hi, m_lo});
      default: ;
    endcase
    if (op != 3'd3 && op != 3'd4) check("rd_zero", bus.rd_data, 0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (op != 3'd1 && op != 3'd2) begin
      check("hi_after_op", bus.hi_out, m_hi);
      check("lo_after_op", bus.lo_out, m_lo);
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((!bus.op_ready || sb.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !bus.op_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending ready=%b expected 0 pending ready=1", sb.size(), bus.op_ready);
    end
  endtask
  function automatic logic [31:0] rnd();
    return $urandom_range(0, 1) ? 32'($urandom_range(0, 400)) - 32'd200 : $urandom;
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    logic [31:0] prev_lo;
    int cnt;
    logic [2:0] op;
    logic [31:0] a, b;
    bus.op_valid = 1'b0;
    bus.op_code = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_regs", {bus.hi_out, bus.lo_out}, 0);
    check("reset_div_ops", {bus.div_a, bus.div_b}, 0);
    check("reset_pulses", {bus.div_start, bus.mul_start, bus.op_done, bus.div_zero_exc, bus.timeout_err, bus.illegal_op}, 0);
    check("reset_ready", {bus.op_ready, bus.stall}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    issue(3'd2, 32'd100, 32'd7);
    drain();
    check("div100_7", {bus.hi_out, bus.lo_out}, {32'd2, 32'd14});
    check("ready_after_div", bus.op_ready, 1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    drain();
    check("divm7_2", {bus.hi_out, bus.lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(3'd4, 0, 0);
    issue(3'd5, 32'hAAAA_5555, 0);
    issue(3'd6, 32'h1234, 0);
    issue(3'd2, 32'd77, 32'd0);
    drain();
    check("divzero_keep", {bus.hi_out, bus.lo_out}, {32'hAAAA_5555, 32'h1234});
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    drain();
    check("mul_2_32", {bus.hi_out, bus.lo_out}, 64'h1_0000_0000);
    issue(3'd1, 32'hFFFF_FFFF, 32'd1);
    drain();
    check("mul_m1", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd7, 32'd3, 32'd4);
    issue(3'd0, 32'd9, 32'd9);
    den = 1'b0;
    issue(3'd2, 32'd9, 32'd3);
    cnt = 1;
    while (!bus.timeout_err && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (!bus.timeout_err && !bus.stall) n_stall_bad++;
    end
    check("timeout_latency", cnt, TIMEOUT + 2);
    drain();
    check("timeout_ready", bus.op_ready, 1);
    den = 1'b1;
    dlat = 15;
    prev_lo = bus.lo_out;
    issue(3'd2, 32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code = 3'd6;
    bus.rs_val = 32'h5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_code = 3'd0;
    check("busy_mtlo_ignored", bus.lo_out, prev_lo);
    drain();
    check("div_after_busy", bus.lo_out, 32'd100);
    dlat = 20;
    issue(3'd2, 32'd77, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    check("midop_reset", {bus.hi_out, bus.lo_out, 31'd0, bus.op_ready}, 96'd1);
    repeat (30) @(negedge clk);
    check("stale_done_ignored", {bus.hi_out, bus.lo_out}, 0);
    dlat = 3;
    issue(3'd2, 32'd50, 32'hFFFF_FFFA);
    drain();
    check("div_after_stale", {bus.hi_out, bus.lo_out}, {32'd2, 32'hFFFF_FFF8});
    repeat (200) begin
      op = 3'($urandom_range(0, 7));
      a = rnd();
      b = $urandom_range(0, 7) == 0 ? 32'd0 : rnd();
      dlat = $urandom_range(1, 25);
      mlat = $urandom_range(1, 6);
      issue(op, a, b);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);
    check("div_start_count", n_dstart, n_div);
    check("mul_start_count", n_mstart, n_mul);
    check("stall_consistent", n_stall_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
